// File: rtl/oled_spi_streamer_if.sv
// Pixel-store read port and OLED pin bundle for oled_spi_streamer.
// The streamer is the master; the pixel store and panel side form the slave.
interface oled_spi_streamer_if;
  logic [7:0] pixelData;
  logic [9:0] pixelAddress;
  logic       io_sclk;
  logic       io_sdin;
  logic       io_cs;
  logic       io_dc;
  logic       io_reset;
  logic       frame_done;

  modport master (
    input  pixelData,
    output pixelAddress, io_sclk, io_sdin, io_cs, io_dc, io_reset, frame_done
  );

  modport slave (
    output pixelData,
    input  pixelAddress, io_sclk, io_sdin, io_cs, io_dc, io_reset, frame_done
  );
endinterface

// File: rtl/oled_spi_streamer.sv
// SSD1306 power-up, 25-byte init sequence, then endless 1024-byte frame streaming over 4-wire SPI.
// Pin outputs decode from the state register so an asynchronous reset reaches the pins at once.
module oled_spi_streamer #(
  parameter int unsigned STARTUP_WAIT = 10_000_000
) (
  input logic                  clk,
  input logic                  rst,
  oled_spi_streamer_if.master  bus
);

  localparam logic [31:0] WaitLast = 32'(STARTUP_WAIT - 1);
  localparam logic [4:0]  NumCmds  = 5'd25;

  typedef enum logic [2:0] {
    PWR_WAIT,
    PWR_RST,
    PWR_SETTLE,
    LOAD_CMD,
    SEND,
    LOAD_DATA
  } state_e;

  state_e      state, stateNext;
  logic [31:0] waitCnt, waitCntNext;
  logic [4:0]  cmdIndex, cmdIndexNext;
  logic [3:0]  phase, phaseNext;
  logic [7:0]  shiftReg, shiftRegNext;
  logic        dcReg, dcRegNext;
  logic [9:0]  addrReg, addrRegNext;
  logic        lastByte, lastByteNext;
  logic        frameDone, frameDoneNext;

  function automatic logic [7:0] cmdRom(input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:    b = 8'hAE;
      5'd1:    b = 8'hD5;
      5'd2:    b = 8'h80;
      5'd3:    b = 8'hA8;
      5'd4:    b = 8'h3F;
      5'd5:    b = 8'hD3;
      5'd6:    b = 8'h00;
      5'd7:    b = 8'h40;
      5'd8:    b = 8'h8D;
      5'd9:    b = 8'h14;
      5'd10:   b = 8'h20;
      5'd11:   b = 8'h00;
      5'd12:   b = 8'hA1;
      5'd13:   b = 8'hC8;
      5'd14:   b = 8'hDA;
      5'd15:   b = 8'h12;
      5'd16:   b = 8'h81;
      5'd17:   b = 8'h7F;
      5'd18:   b = 8'hD9;
      5'd19:   b = 8'hF1;
      5'd20:   b = 8'hDB;
      5'd21:   b = 8'h40;
      5'd22:   b = 8'hA4;
      5'd23:   b = 8'hA6;
      5'd24:   b = 8'hAF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PWR_WAIT;
      waitCnt   <= '0;
      cmdIndex  <= '0;
      phase     <= '0;
      shiftReg  <= '0;
      dcReg     <= 1'b0;
      addrReg   <= '0;
      lastByte  <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      state     <= stateNext;
      waitCnt   <= waitCntNext;
      cmdIndex  <= cmdIndexNext;
      phase     <= phaseNext;
      shiftReg  <= shiftRegNext;
      dcReg     <= dcRegNext;
      addrReg   <= addrRegNext;
      lastByte  <= lastByteNext;
      frameDone <= frameDoneNext;
    end
  end

  always_comb begin
    stateNext     = state;
    waitCntNext   = waitCnt;
    cmdIndexNext  = cmdIndex;
    phaseNext     = phase;
    shiftRegNext  = shiftReg;
    dcRegNext     = dcReg;
    addrRegNext   = addrReg;
    lastByteNext  = lastByte;
    frameDoneNext = 1'b0;

    unique case (state)
      PWR_WAIT, PWR_RST, PWR_SETTLE: begin
        if (waitCnt == WaitLast) begin
          waitCntNext = '0;
          unique case (state)
            PWR_WAIT: stateNext = PWR_RST;
            PWR_RST:  stateNext = PWR_SETTLE;
            default:  stateNext = LOAD_CMD;
          endcase
        end else begin
          waitCntNext = waitCnt + 32'd1;
        end
      end
      LOAD_CMD: begin
        shiftRegNext = cmdRom(cmdIndex);
        dcRegNext    = 1'b0;
        cmdIndexNext = cmdIndex + 5'd1;
        lastByteNext = 1'b0;
        phaseNext    = '0;
        stateNext    = SEND;
      end
      LOAD_DATA: begin
        shiftRegNext = bus.pixelData;
        dcRegNext    = 1'b1;
        // 10-bit counter wraps 1023 -> 0 on its own
        addrRegNext  = addrReg + 10'd1;
        lastByteNext = (addrReg == 10'd1023);
        phaseNext    = '0;
        stateNext    = SEND;
      end
      SEND: begin
        phaseNext = phase + 4'd1;
        // Shift after the high phase so the next bit appears while sclk is low
        if (phase[0]) begin
          shiftRegNext = {shiftReg[6:0], 1'b0};
        end
        if (phase == 4'd15) begin
          frameDoneNext = lastByte;
          stateNext     = (cmdIndex < NumCmds) ? LOAD_CMD : LOAD_DATA;
        end
      end
      default: stateNext = PWR_WAIT;
    endcase
  end

  assign bus.io_reset     = (state != PWR_RST);
  assign bus.io_cs        = (state != SEND);
  assign bus.io_sclk      = (state == SEND) && phase[0];
  assign bus.io_sdin      = (state == SEND) && shiftReg[7];
  assign bus.io_dc        = dcReg;
  assign bus.pixelAddress = addrReg;
  assign bus.frame_done   = frameDone;

endmodule

// File: tb/tb_oled_spi_streamer.sv
// Bench for oled_spi_streamer: a timeline model derived from byte index and bit phase,
// an SPI decoder, pin hygiene monitors and a few literal expectations.
module tb_oled_spi_streamer;

  localparam int SW       = 4;
  localparam int ByteCyc  = 17;
  localparam int NumCmds  = 25;
  localparam int FrameCyc = 17408;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  oled_spi_streamer_if bus ();

  oled_spi_streamer #(
    .STARTUP_WAIT (SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] rom [NumCmds];
  logic [7:0] mem [1024];
  logic       xorMode = 1'b1;
  logic       running = 1'b0;
  int         nPass = 0;
  int         nChecks = 0;
  int         cyc;

  // Upstream pixel store: registered read, one cycle of latency
  always @(posedge clk) begin
    if (xorMode) bus.pixelData <= bus.pixelAddress[7:0] ^ 8'h5A;
    else         bus.pixelData <= mem[bus.pixelAddress];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int got, input int exp);
    nChecks++;
    if (got == exp) nPass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
  endtask

  function automatic logic [7:0] dataOf(input int a);
    logic [7:0] v;
    v = 8'(a) ^ 8'h5A;
    return xorMode ? v : mem[a];
  endfunction

  function automatic logic byteDc(input int k);
    return k >= NumCmds;
  endfunction

  function automatic logic [7:0] byteVal(input int k);
    return (k < NumCmds) ? rom[k] : dataOf((k - NumCmds) % 1024);
  endfunction

  // Expected pins for cycle t after reset release, from the byte timeline
  function automatic void modelAt(input int t, output logic eReset, output logic eCs,
                                  output logic eSclk, output logic eSdin, output logic eDc,
                                  output logic eFd, output logic [9:0] eAddr);
    int s, k, p, q;
    logic [7:0] b;
    eReset = !(t >= SW && t < 2 * SW);
    eCs = 1'b1; eSclk = 1'b0; eSdin = 1'b0; eDc = 1'b0; eFd = 1'b0; eAddr = '0;
    if (t < 3 * SW) return;
    s = t - 3 * SW;
    k = s / ByteCyc;
    p = s % ByteCyc;
    if (p == 0) begin
      eDc   = (k > 0) ? byteDc(k - 1) : 1'b0;
      eAddr = (k >= NumCmds) ? 10'((k - NumCmds) % 1024) : 10'd0;
      eFd   = (k >= NumCmds + 1) && (((k - NumCmds - 1) % 1024) == 1023);
    end else begin
      q     = p - 1;
      b     = byteVal(k);
      eCs   = 1'b0;
      eSclk = q[0];
      eSdin = b[3'(7 - q / 2)];
      eDc   = byteDc(k);
      eAddr = (k >= NumCmds) ? 10'((k - NumCmds + 1) % 1024) : 10'd0;
    end
  endfunction

  // Per-cycle compare against the model, plus power-up and frame-pulse literals
  int lastFd = -1;
  always @(negedge clk) begin
    logic eReset, eCs, eSclk, eSdin, eDc, eFd;
    logic [9:0] eAddr;
    if (rst) begin
      lastFd = -1;
    end else if (running) begin
      modelAt(cyc, eReset, eCs, eSclk, eSdin, eDc, eFd, eAddr);
      chk("io_reset", bus.io_reset, eReset);
      chk("io_cs", bus.io_cs, eCs);
      chk("io_sclk", bus.io_sclk, eSclk);
      chk("pixelAddress", bus.pixelAddress, eAddr);
      chk("frame_done", bus.frame_done, eFd);
      if (!eCs || cyc < 3 * SW) begin
        chk("io_sdin", bus.io_sdin, eSdin);
        chk("io_dc", bus.io_dc, eDc);
      end
      if (cyc == 3) chk("lit io_reset c3", bus.io_reset, 1);
      if (cyc == 4) chk("lit io_reset c4", bus.io_reset, 0);
      if (cyc == 7) chk("lit io_reset c7", bus.io_reset, 0);
      if (cyc == 8) chk("lit io_reset c8", bus.io_reset, 1);
      if (cyc == 12) chk("lit io_cs c12", bus.io_cs, 1);
      if (cyc == 13) chk("lit io_cs c13", bus.io_cs, 0);
      if (bus.frame_done) begin
        if (lastFd < 0) chk("lit first frame_done", cyc, 17845);
        else            chk("frame_done period", cyc - lastFd, FrameCyc);
        lastFd = cyc;
      end
    end
  end

  // SPI decoder on sclk rise plus pin hygiene
  logic       pSclk, pSdin, pCs, pDc;
  logic [7:0] dShift;
  int         dBits, dByte;
  always @(negedge clk) begin
    if (rst || !running) begin
      pSclk = 1'b0; pSdin = 1'b0; pCs = 1'b1; pDc = 1'b0;
      dBits = 0; dByte = 0; dShift = '0;
    end else begin
      if (pSclk && bus.io_sclk) chk("sdin stable while sclk high", bus.io_sdin, pSdin);
      if (!pCs && !bus.io_cs)   chk("dc stable while cs low", bus.io_dc, pDc);
      if (bus.io_sclk && !pSclk) begin
        dShift = {dShift[6:0], bus.io_sdin};
        dBits++;
        if (dBits == 8) begin
          chk("decoded byte", dShift, byteVal(dByte));
          chk("decoded dc", bus.io_dc, byteDc(dByte));
          if (dByte == 0)  chk("lit first cmd", dShift, 8'hAE);
          if (dByte == 24) chk("lit last cmd", dShift, 8'hAF);
          if (xorMode && dByte == 25) chk("lit data0", dShift, 8'h5A);
          if (xorMode && dByte == 26) chk("lit data1", dShift, 8'h5B);
          if (xorMode && dByte == 27) chk("lit data2", dShift, 8'h58);
          dBits = 0;
          dByte++;
        end
      end
      pSclk = bus.io_sclk; pSdin = bus.io_sdin; pCs = bus.io_cs; pDc = bus.io_dc;
    end
  end

  initial begin
    int target;
    rom = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
            8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'h7F, 8'hD9, 8'hF1,
            8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

    // Run past two frame wraps, then hit reset during bit 3 of a random data byte
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    running = 1'b1;
    target = 3 * SW + ByteCyc * (NumCmds + 2048 + int'($urandom_range(0, 40))) + 9;
    repeat (target) @(posedge clk);
    #2;
    chk("mid-byte cs low before reset", bus.io_cs, 0);
    rst = 1'b1;
    running = 1'b0;
    #1;
    chk("reset io_cs", bus.io_cs, 1);
    chk("reset io_sclk", bus.io_sclk, 0);
    chk("reset pixelAddress", bus.pixelAddress, 0);
    chk("reset io_reset", bus.io_reset, 1);
    chk("reset io_dc", bus.io_dc, 0);
    chk("reset io_sdin", bus.io_sdin, 0);
    chk("reset frame_done", bus.frame_done, 0);

    // Second pass: random pixel store contents, full power-up and commands again
    repeat (2) @(posedge clk);
    xorMode = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    @(posedge clk);
    #2 rst = 1'b0;
    running = 1'b1;
    repeat (3 * SW + ByteCyc * NumCmds + FrameCyc + 300) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/oled_spi_streamer.md
# oled_spi_streamer

Downstream consumer of the text engine's 1 KiB pixel store. It powers up and configures an SSD1306-class 128x64 OLED over 4-wire SPI. It then reads `pixelData` byte-by-byte via `pixelAddress` and streams all 1024 bytes to the panel in horizontal addressing mode, looping forever. It is the only block driving the OLED pins.

## Interface
- `STARTUP_WAIT`, default 10_000_000: cycles spent in each of the three power-up phases.
- `clk` input 1: system clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `pixelData` input 8: byte from the pixel store. Registered upstream, so valid 1 cycle after `pixelAddress` changes.
- `pixelAddress` output 10: byte index into the pixel store, 0..1023. Reset value 0.
- `io_sclk` output 1: SPI clock, idle low. Reset value 0.
- `io_sdin` output 1: SPI data, MSB first. Reset value 0.
- `io_cs` output 1: chip select, active low. Reset value 1.
- `io_dc` output 1: 0 = command, 1 = data. Reset value 0.
- `io_reset` output 1: panel reset, active low. Reset value 1.
- `frame_done` output 1: 1-cycle pulse after the last bit of byte 1023. Reset value 0.

## Operation
- State machine states: `PWR_WAIT`, `PWR_RST`, `PWR_SETTLE`, `LOAD_CMD`, `SEND`, `LOAD_DATA`.
- `PWR_WAIT`:
  - `io_reset`=1 for STARTUP_WAIT cycles.
  - Then `PWR_RST` with `io_reset`=0 for STARTUP_WAIT cycles.
  - Then `PWR_SETTLE` with `io_reset`=1 for STARTUP_WAIT cycles.
  - Then `LOAD_CMD`.
- The wait counter is 32 bits and clears on every phase change.
- Command ROM holds 25 bytes, sent in order:
  - AE, D5 80, A8 3F, D3 00, 40, 8D 14, 20 00
  - A1, C8, DA 12, 81 7F, D9 F1, DB 40, A4, A6, AF
- `LOAD_CMD` (1 cycle):
  - Shift register loads ROM[cmdIndex]; `io_dc`<=0; cmdIndex increments.
  - `io_cs`=1, `io_sclk`=0.
  - Next state is `SEND`.
- `LOAD_DATA` (1 cycle):
  - Shift register loads `pixelData`; `io_dc`<=1.
  - `pixelAddress` increments with wrap 1023->0.
  - `io_cs`=1, `io_sclk`=0.
  - Next state is `SEND`.
- `SEND` (16 cycles, bit 7 down to 0):
  - `io_cs`=0 throughout.
  - Even phase: `io_sclk`=0 and `io_sdin`=current bit.
  - Odd phase: `io_sclk`=1, with `io_sdin` held.
  - After bit 0's high phase, the exit depends on progress:
    - If cmdIndex < 25, go to `LOAD_CMD`.
    - Otherwise go to `LOAD_DATA`.
- Once the 25th command completes, the block never returns to `LOAD_CMD` except through `rst`.
- `frame_done` pulses on the cycle `SEND` completes with the just-sent byte taken from address 1023.
- `rst` asserted at any time, including mid-byte: all state and outputs return to reset values immediately. The sequence restarts at `PWR_WAIT`.

## Timing
- After `rst` deassertion, the first `LOAD_CMD` cycle is cycle 3*STARTUP_WAIT.
- Each byte takes 17 cycles (1 load + 16 shift). The command phase takes 425 cycles. One frame takes 17408 cycles.
- `pixelAddress` is stable for 16 cycles before each `LOAD_DATA` sample, which covers the 1-cycle upstream read latency with margin.
- The first data byte is read from address 0. During the whole command phase, `pixelAddress` holds at 0.
- The panel samples `io_sdin` on the `io_sclk` rising edge. `io_sdin` changes only while `io_sclk`=0, at least 1 cycle before the rise.
- `io_dc` changes only in load cycles, while `io_cs`=1.

## Test plan
- **Power-up timing:** STARTUP_WAIT=4, pulse `rst` -> `io_reset` reads 1 for cycles 0-3, 0 for 4-7, 1 from 8 on; first `io_cs` fall at cycle 13.
- **Command stream:** decode SPI on `io_sclk` rise with `io_dc`=0 -> exactly 25 bytes matching ROM order (AE first, AF last); `io_cs` high for 1 cycle between bytes.
- **Data stream:** model upstream with 1-cycle registered read returning `pixelAddress[7:0]` ^ 8'h5A -> data bytes decoded with `io_dc`=1 are 5A,5B,58,... for addresses 0..1023 in order.
- **Wrap and frame pulse:** run past 1024 data bytes -> `frame_done` pulses once per 17408 cycles; the byte after address 1023 comes from address 0; no further commands are sent.
- **Mid-byte reset:** assert `rst` during bit 3 of a data byte -> same cycle, `io_cs`=1, `io_sclk`=0, `pixelAddress`=0; after release, the full power-up and 25 commands repeat.
- **Signal hygiene:** monitor across a full frame -> `io_sdin` never changes while `io_sclk`=1, and `io_dc` never changes while `io_cs`=0.
